dac_spi_tx: RTL and testbench

- Serial transmitter that drives the board's 10-bit SPI DAC (MCP4911-style, 16-bit write frame) from parallel samples produced by the audio processing path.
- Sits at the output end of the sample chain, mirroring the ADC capture side.
- Accepts one sample per load strobe, serialises it with fixed config bits, then pulses the DAC latch.
- One-deep holding register absorbs a sample arriving mid-frame; anything beyond that is dropped and flagged.

---
 rtl/dac_spi_tx_pkg.sv | 18 +
 rtl/spi_tick_gen.sv | 16 +
 rtl/dac_spi_tx.sv | 75 +++++++
 tb/tb_dac_spi_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_tx_pkg.sv
// dac_spi_tx_pkg: frame layout, FSM encoding and frame builder for the DAC SPI transmitter
`timescale 1ns/1ps
package dac_spi_tx_pkg;
  localparam int FRAME_W  = 16;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, LATCH} state_t;
  function automatic logic [FRAME_W-1:0] make_frame(input logic vref_buf, input logic ga_n,
                                                    input logic shdn_n, input logic [9:0] d);
    logic [FRAME_W-1:0] f;
    f = FRAME_W'({d, 2'b00});
    f[BUF_BIT] = vref_buf;
    f[GA_BIT] = ga_n;
    f[SHDN_BIT] = shdn_n;
    return f;
  endfunction
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: SCK half-period tick, counter held at zero while disabled
`timescale 1ns/1ps
module spi_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic sysclk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = en && cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge sysclk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 10-bit samples into MCP4911-style 16-bit SPI frames with LDAC pulse
`timescale 1ns/1ps
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int   CLK_DIV    = 25,
  parameter logic CFG_BUF    = 1'b0,
  parameter logic CFG_GA_N   = 1'b1,
  parameter logic CFG_SHDN_N = 1'b1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       dac_cs,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld,
  output logic       busy,
  output logic       overrun
);
  state_t state, state_nxt;
  logic tick, in_idle, start, hold_full;
  logic [9:0] hold;
  logic [4:0] half;
  logic [FRAME_W-1:0] sr;
  assign in_idle = state == IDLE;
  assign start = in_idle && (hold_full || load);
  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .sysclk(sysclk),
    .reset (reset),
    .en    (!in_idle),
    .tick  (tick)
  );
  always_ff @(posedge sysclk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = start ? CS_SETUP : IDLE;
      CS_SETUP: state_nxt = tick ? SHIFT : CS_SETUP;
      SHIFT:    state_nxt = (tick && half == 5'd31) ? CS_HOLD : SHIFT;
      CS_HOLD:  state_nxt = tick ? LATCH : CS_HOLD;
      LATCH:    state_nxt = tick ? IDLE : LATCH;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      hold_full <= 1'b0;
      hold <= '0;
      sr <= '0;
      half <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && !in_idle && hold_full;
      // In IDLE the held sample leaves for the shifter, so a coincident load can refill the slot
      if (in_idle && hold_full) begin
        hold_full <= load;
        if (load) hold <= data_in;
      end else if (load && !in_idle && !hold_full) begin
        hold_full <= 1'b1;
        hold <= data_in;
      end
      if (start) sr <= make_frame(CFG_BUF, CFG_GA_N, CFG_SHDN_N, hold_full ? hold : data_in);
      else if (state == SHIFT && tick && half[0]) sr <= {sr[FRAME_W-2:0], 1'b0};
      half <= (state != SHIFT) ? '0 : tick ? half + 5'd1 : half;
    end
  assign dac_cs  = in_idle || state == LATCH;
  assign dac_sck = state == SHIFT && half[0];
  assign dac_sdi = sr[FRAME_W-1];
  assign dac_ld  = state != LATCH;
  assign busy    = !in_idle || hold_full;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed checks of framing, latch pulse, holding register, overrun and reset abort
`timescale 1ns/1ps
module tb_dac_spi_tx;
  logic sysclk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] load_r = '0;
  logic [9:0] din_r [2];
  logic [1:0] cs_w, sck_w, sdi_w, ld_w, busy_w, ovr_w;
  int n_cmp = 0, n_bad = 0;

  always #5 sysclk = ~sysclk;

  dac_spi_tx #(.CLK_DIV(4)) u_dut4 (
    .sysclk(sysclk), .reset(reset), .data_in(din_r[0]), .load(load_r[0]),
    .dac_cs(cs_w[0]), .dac_sck(sck_w[0]), .dac_sdi(sdi_w[0]), .dac_ld(ld_w[0]),
    .busy(busy_w[0]), .overrun(ovr_w[0])
  );
  dac_spi_tx #(.CLK_DIV(2)) u_dut2 (
    .sysclk(sysclk), .reset(reset), .data_in(din_r[1]), .load(load_r[1]),
    .dac_cs(cs_w[1]), .dac_sck(sck_w[1]), .dac_sdi(sdi_w[1]), .dac_ld(ld_w[1]),
    .busy(busy_w[1]), .overrun(ovr_w[1])
  );

  logic [15:0] cap [2];
  logic [15:0] fw [2][32];
  int fr [2][32], fcs [2][32], gap [2][32], ldw [2][32];
  int nrise [2], csl [2], csh [2], ldl [2], fn [2], ldn [2], novr [2], sck_bad [2];
  logic p_sck [2], p_cs [2], p_ld [2];

  initial for (int k = 0; k < 2; k++) begin
    din_r[k] = '0; cap[k] = '0; nrise[k] = 0; csl[k] = 0; csh[k] = 0; ldl[k] = 0;
    fn[k] = 0; ldn[k] = 0; novr[k] = 0; sck_bad[k] = 0; p_sck[k] = 0; p_cs[k] = 1; p_ld[k] = 1;
  end

  // Bus observer: rebuilds each frame from SDI at SCK rises and measures pulse widths
  always @(negedge sysclk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        cap[k] = '0; nrise[k] = 0; csl[k] = 0; csh[k] = 0; ldl[k] = 0;
        p_sck[k] = 1'b0; p_cs[k] = 1'b1; p_ld[k] = 1'b1;
      end else begin
        if (sck_w[k] && !p_sck[k]) begin
          cap[k] = {cap[k][14:0], sdi_w[k]};
          nrise[k]++;
        end
        if (sck_w[k] && cs_w[k]) sck_bad[k]++;
        if (!cs_w[k]) csl[k]++; else csh[k]++;
        if (cs_w[k] && !p_cs[k]) begin
          if (fn[k] < 32) begin fw[k][fn[k]] = cap[k]; fr[k][fn[k]] = nrise[k]; fcs[k][fn[k]] = csl[k]; end
          fn[k]++; cap[k] = '0; nrise[k] = 0; csl[k] = 0;
        end
        if (!cs_w[k] && p_cs[k]) begin
          if (fn[k] < 32) gap[k][fn[k]] = csh[k];
          csh[k] = 0;
        end
        if (!ld_w[k]) ldl[k]++;
        if (ld_w[k] && !p_ld[k]) begin
          if (ldn[k] < 32) ldw[k][ldn[k]] = ldl[k];
          ldn[k]++; ldl[k] = 0;
        end
        if (ovr_w[k]) novr[k]++;
        p_sck[k] = sck_w[k]; p_cs[k] = cs_w[k]; p_ld[k] = ld_w[k];
      end
    end
  end

  function automatic logic [15:0] exp_frame(input logic [9:0] d);
    return {4'b0011, d, 2'b00};
  endfunction

  task automatic do_load(input int k, input logic [9:0] d);
    @(posedge sysclk); #1;
    load_r[k] = 1'b1; din_r[k] = d;
    @(posedge sysclk); #1;
    load_r[k] = 1'b0; din_r[k] = ~d;
  endtask

  task automatic wait_frames(input int k, input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && fn[k] < n; i++) @(posedge sysclk);
    #1 ok = fn[k] >= n;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge sysclk);
    #1;
    n_cmp += 6;
    if (cs_w[0] !== 1'b1) begin n_bad++; $display("FAIL reset_cs: got %b expected 1", cs_w[0]); end
    if (sck_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b expected 0", sck_w[0]); end
    if (sdi_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_sdi: got %b expected 0", sdi_w[0]); end
    if (ld_w[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ld: got %b expected 1", ld_w[0]); end
    if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_w[0]); end
    if (ovr_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", ovr_w[0]); end
    @(negedge sysclk) reset = 1'b0;
    repeat (3) @(posedge sysclk);
  endtask

  task automatic test_single;
    int b, bl;
    bit ok;
    b = fn[0]; bl = ldn[0];
    do_load(0, 10'h2AB);
    n_cmp += 2;
    if (cs_w[0] !== 1'b0) begin n_bad++; $display("FAIL single_latency_cs: got %b expected 0", cs_w[0]); end
    if (busy_w[0] !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy_w[0]); end
    wait_frames(0, b + 1, 400, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d frames expected %0d", fn[0], b + 1); end
    else begin
      repeat (10) @(posedge sysclk);
      #1;
      n_cmp += 7;
      if (fw[0][b] !== 16'h3AAC) begin n_bad++; $display("FAIL single_word: got %h expected 3aac", fw[0][b]); end
      if (fr[0][b] != 16) begin n_bad++; $display("FAIL single_rises: got %0d expected 16", fr[0][b]); end
      if (fcs[0][b] != 136) begin n_bad++; $display("FAIL single_cs_low: got %0d expected 136", fcs[0][b]); end
      if (ldn[0] != bl + 1) begin n_bad++; $display("FAIL single_ld_count: got %0d expected %0d", ldn[0], bl + 1); end
      if (ldw[0][bl] != 4) begin n_bad++; $display("FAIL single_ld_width: got %0d expected 4", ldw[0][bl]); end
      if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b expected 0", busy_w[0]); end
      if (cs_w[0] !== 1'b1) begin n_bad++; $display("FAIL single_idle_cs: got %b expected 1", cs_w[0]); end
    end
  endtask

  task automatic test_patterns;
    logic [9:0] d [2];
    logic [15:0] e [2];
    int b;
    bit ok;
    d[0] = 10'h000; e[0] = 16'h3000;
    d[1] = 10'h3FF; e[1] = 16'h3FFC;
    for (int i = 0; i < 2; i++) begin
      b = fn[0];
      do_load(0, d[i]);
      wait_frames(0, b + 1, 400, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL pattern_timeout: got %0d frames expected %0d", fn[0], b + 1); end
      else begin
        n_cmp += 2;
        if (fw[0][b] !== e[i]) begin n_bad++; $display("FAIL pattern_word: got %h expected %h", fw[0][b], e[i]); end
        if (fr[0][b] != 16) begin n_bad++; $display("FAIL pattern_rises: got %0d expected 16", fr[0][b]); end
      end
      repeat (10) @(posedge sysclk);
    end
    #1;
    n_cmp += 2;
    if (sck_bad[0] != 0) begin n_bad++; $display("FAIL sck_outside_cs: got %0d expected 0", sck_bad[0]); end
    if (sck_w[0] !== 1'b0) begin n_bad++; $display("FAIL sck_idle: got %b expected 0", sck_w[0]); end
  endtask

  task automatic test_back_to_back;
    int b, o, blow, i;
    b = fn[0]; o = novr[0]; blow = 0;
    do_load(0, 10'h0AA);
    repeat (48) @(posedge sysclk);
    do_load(0, 10'h155);
    for (i = 0; i < 600 && fn[0] < b + 2; i++) begin
      @(posedge sysclk); #1;
      if (!busy_w[0]) blow++;
    end
    n_cmp++;
    if (fn[0] < b + 2) begin n_bad++; $display("FAIL b2b_timeout: got %0d frames expected %0d", fn[0], b + 2); end
    else begin
      n_cmp += 5;
      if (blow != 0) begin n_bad++; $display("FAIL b2b_busy_gap: got %0d idle cycles expected 0", blow); end
      if (fw[0][b] !== 16'h32A8) begin n_bad++; $display("FAIL b2b_word0: got %h expected 32a8", fw[0][b]); end
      if (fw[0][b+1] !== 16'h3554) begin n_bad++; $display("FAIL b2b_word1: got %h expected 3554", fw[0][b+1]); end
      if (gap[0][b+1] != 5) begin n_bad++; $display("FAIL b2b_cs_gap: got %0d expected 5", gap[0][b+1]); end
      if (novr[0] != o) begin n_bad++; $display("FAIL b2b_overrun: got %0d expected %0d", novr[0] - o, 0); end
    end
    repeat (10) @(posedge sysclk);
  endtask

  task automatic test_overrun;
    int b, o;
    bit ok;
    b = fn[0]; o = novr[0];
    do_load(0, 10'h100);
    repeat (20) @(posedge sysclk);
    do_load(0, 10'h101);
    repeat (20) @(posedge sysclk);
    do_load(0, 10'h102);
    wait_frames(0, b + 2, 600, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ovr_timeout: got %0d frames expected %0d", fn[0], b + 2); end
    else begin
      repeat (300) @(posedge sysclk);
      #1;
      n_cmp += 4;
      if (fw[0][b] !== 16'h3400) begin n_bad++; $display("FAIL ovr_word0: got %h expected 3400", fw[0][b]); end
      if (fw[0][b+1] !== 16'h3404) begin n_bad++; $display("FAIL ovr_word1: got %h expected 3404", fw[0][b+1]); end
      if (fn[0] != b + 2) begin n_bad++; $display("FAIL ovr_extra_frame: got %0d frames expected %0d", fn[0], b + 2); end
      if (novr[0] - o != 1) begin n_bad++; $display("FAIL ovr_pulse_cycles: got %0d expected 1", novr[0] - o); end
    end
  endtask

  task automatic test_reset_mid;
    int b, bl;
    bit ok;
    b = fn[0]; bl = ldn[0];
    do_load(0, 10'h100);
    do_load(0, 10'h101);
    for (int i = 0; i < 300 && nrise[0] < 8; i++) @(negedge sysclk);
    n_cmp++;
    if (nrise[0] < 8) begin n_bad++; $display("FAIL mid_reach_edge8: got %0d rises expected 8", nrise[0]); end
    @(posedge sysclk); #2;
    reset = 1'b1;
    #1;
    n_cmp += 4;
    if (cs_w[0] !== 1'b1) begin n_bad++; $display("FAIL mid_async_cs: got %b expected 1", cs_w[0]); end
    if (sck_w[0] !== 1'b0) begin n_bad++; $display("FAIL mid_async_sck: got %b expected 0", sck_w[0]); end
    if (ld_w[0] !== 1'b1) begin n_bad++; $display("FAIL mid_async_ld: got %b expected 1", ld_w[0]); end
    if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL mid_async_busy: got %b expected 0", busy_w[0]); end
    repeat (3) @(posedge sysclk);
    @(negedge sysclk) reset = 1'b0;
    repeat (200) @(posedge sysclk);
    #1;
    n_cmp += 3;
    if (fn[0] != b) begin n_bad++; $display("FAIL mid_no_frame: got %0d frames expected %0d", fn[0], b); end
    if (ldn[0] != bl) begin n_bad++; $display("FAIL mid_no_latch: got %0d pulses expected %0d", ldn[0], bl); end
    if (cs_w[0] !== 1'b1) begin n_bad++; $display("FAIL mid_hold_discard: got cs %b expected 1", cs_w[0]); end
    do_load(0, 10'h3FF);
    wait_frames(0, b + 1, 400, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_clean_timeout: got %0d frames expected %0d", fn[0], b + 1); end
    else begin
      n_cmp += 2;
      if (fw[0][b] !== 16'h3FFC) begin n_bad++; $display("FAIL mid_clean_word: got %h expected 3ffc", fw[0][b]); end
      if (fr[0][b] != 16) begin n_bad++; $display("FAIL mid_clean_rises: got %0d expected 16", fr[0][b]); end
    end
  endtask

  task automatic test_max_rate;
    logic [9:0] d [5];
    int b, o;
    bit ok;
    d[0] = 10'h001; d[1] = 10'h200; d[2] = 10'h3FF; d[3] = 10'h0F0; d[4] = 10'h2AB;
    b = fn[1]; o = novr[1];
    for (int i = 0; i < 5; i++) begin
      do_load(1, d[i]);
      repeat (68) @(posedge sysclk);
    end
    wait_frames(1, b + 5, 800, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL max_timeout: got %0d frames expected %0d", fn[1], b + 5); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp += 3;
        if (fw[1][b+i] !== exp_frame(d[i])) begin n_bad++; $display("FAIL max_word%0d: got %h expected %h", i, fw[1][b+i], exp_frame(d[i])); end
        if (fr[1][b+i] != 16) begin n_bad++; $display("FAIL max_rises%0d: got %0d expected 16", i, fr[1][b+i]); end
        if (fcs[1][b+i] != 68) begin n_bad++; $display("FAIL max_cs_low%0d: got %0d expected 68", i, fcs[1][b+i]); end
        if (i > 0) begin
          n_cmp++;
          if (gap[1][b+i] != 3) begin n_bad++; $display("FAIL max_gap%0d: got %0d expected 3", i, gap[1][b+i]); end
        end
      end
      n_cmp++;
      if (novr[1] != o) begin n_bad++; $display("FAIL max_overrun: got %0d expected 0", novr[1] - o); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_patterns;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    test_max_rate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
